// File: rtl/awg_rle_loader.sv
// awg_rle_loader: buffers run-length-encoded sample commands and expands them into memory write beats, then pulses run
module awg_rle_loader #(
    parameter int NUM_SIG    = 8,
    parameter int NUM_SAMP   = 128,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        axi_clk,
    input  logic                        axi_resetn,
    input  logic                        clear,
    input  logic [NUM_SIG-1:0]          cmd_pattern,
    input  logic [CNT_W-1:0]            cmd_count,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        go,
    output logic [NUM_SIG-1:0]          write_channel,
    output logic                        write_channel_wrStrobe,
    output logic                        run,
    output logic                        busy,
    output logic [$clog2(NUM_SAMP):0]   samples_written,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(NUM_SAMP) + 1;

    typedef enum logic [1:0] {IDLE, EXPAND, RUNPULSE} state_t;

    state_t             state, state_n;
    logic [NUM_SIG-1:0] fifo_pat [FIFO_DEPTH];
    logic [CNT_W-1:0]   fifo_cnt [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic               ready_r, fifo_empty, fifo_full, push, pop, last;
    logic [NUM_SIG-1:0] pat_r, pat_n, wc_n;
    logic [CNT_W-1:0]   rem_r, rem_n;
    logic               go_pending, go_pending_n, beat_n, strobe_n, overflow_n, busy_n;
    logic [SW-1:0]      sw_n;

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = ready_r && !fifo_full && !clear;
    assign push       = cmd_valid && cmd_ready;
    assign last       = rem_r <= CNT_W'(1);

    // command storage; contents need no reset since the pointers define validity
    always_ff @(posedge axi_clk) begin
        if (push) begin
            fifo_pat[wr_ptr[AW-1:0]] <= cmd_pattern;
            fifo_cnt[wr_ptr[AW-1:0]] <= cmd_count;
        end
    end

    // next state, pops, and next values of every registered output
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        rem_n   = rem_r;
        pat_n   = pat_r;
        case (state)
            IDLE: begin
                pop     = !fifo_empty;
                state_n = !fifo_empty ? EXPAND : go_pending ? RUNPULSE : IDLE;
            end
            EXPAND: begin
                pop     = last && !fifo_empty;
                rem_n   = last ? rem_r : rem_r - CNT_W'(1);
                state_n = (!last || !fifo_empty) ? EXPAND : go_pending ? RUNPULSE : IDLE;
            end
            RUNPULSE: state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (clear) begin
            state_n = IDLE;
            pop     = 1'b0;
        end
        if (pop) begin
            pat_n = fifo_pat[rd_ptr[AW-1:0]];
            rem_n = fifo_cnt[rd_ptr[AW-1:0]];
        end
        wr_ptr_n     = clear ? '0 : wr_ptr + (AW+1)'(push);
        rd_ptr_n     = clear ? '0 : rd_ptr + (AW+1)'(pop);
        go_pending_n = !clear && (state == RUNPULSE ? 1'b0 : (go_pending || go));
        sw_n         = clear ? '0 : samples_written + SW'(write_channel_wrStrobe);
        beat_n       = state_n == EXPAND && rem_n != '0;
        strobe_n     = beat_n && sw_n != SW'(NUM_SAMP);
        overflow_n   = !clear && (overflow || (beat_n && sw_n == SW'(NUM_SAMP)));
        wc_n         = strobe_n ? pat_n : write_channel;
        busy_n       = wr_ptr_n != rd_ptr_n || state_n == EXPAND || go_pending_n;
    end

    // state and output registers; reset drops every output asynchronously
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state                  <= IDLE;
            ready_r                <= 1'b0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            pat_r                  <= '0;
            rem_r                  <= '0;
            go_pending             <= 1'b0;
            write_channel          <= '0;
            write_channel_wrStrobe <= 1'b0;
            run                    <= 1'b0;
            busy                   <= 1'b0;
            samples_written        <= '0;
            overflow               <= 1'b0;
        end else begin
            state                  <= state_n;
            ready_r                <= 1'b1;
            wr_ptr                 <= wr_ptr_n;
            rd_ptr                 <= rd_ptr_n;
            pat_r                  <= pat_n;
            rem_r                  <= rem_n;
            go_pending             <= go_pending_n;
            write_channel          <= wc_n;
            write_channel_wrStrobe <= strobe_n;
            run                    <= state_n == RUNPULSE;
            busy                   <= busy_n;
            samples_written        <= sw_n;
            overflow               <= overflow_n;
        end
    end
endmodule
